// File: rtl/pin_scan_ctrl_if.sv
// Bundle between the pin scan controller and its environment (run control,
// blink-code encoder handshake, scan position and pin drive outputs).
interface pin_scan_ctrl_if #(
  parameter int NUM_COLS = 16,
  parameter int NUM_ROWS = 8
);
  // Handshake: enc_start is a single-cycle request issued only while enc_busy
  // is low; the encoder raises enc_busy on the following cycle and drops it
  // when the blink code is finished, which releases the controller to DRIVE.
  logic                         run;
  logic                         loop;
  logic                         enc_busy;
  logic                         enc_start;
  logic [6:0]                   col;
  logic [6:0]                   row;
  logic [NUM_COLS*NUM_ROWS-1:0] pin_drive;
  logic                         busy;
  logic                         scan_done;
  logic [2:0]                   state_dbg;

  modport master (
    input  run, loop, enc_busy,
    output enc_start, col, row, pin_drive, busy, scan_done, state_dbg
  );

  modport slave (
    output run, loop, enc_busy,
    input  enc_start, col, row, pin_drive, busy, scan_done, state_dbg
  );
endinterface

// File: rtl/pin_scan_ctrl.sv
// Walks every pin of a column/row grid: announce it through the blink encoder,
// toggle it for a dwell period, then idle for a gap before the next pin.
module pin_scan_ctrl #(
  parameter int NUM_COLS   = 16,
  parameter int NUM_ROWS   = 8,
  parameter int DWELL_CYC  = 1024,
  parameter int GAP_CYC    = 64,
  parameter int TOGGLE_DIV = 3
) (
  input  logic           clk,
  input  logic           reset,
  pin_scan_ctrl_if.master bus
);
  localparam int NUM_PINS = NUM_COLS * NUM_ROWS;
  localparam int PIN_W    = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam int DWELL_W  = $clog2(DWELL_CYC);
  localparam int GAP_W    = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ANNOUNCE = 3'd1,
    WAIT_ENC = 3'd2,
    DRIVE    = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [6:0]           col, col_n;
  logic [6:0]           row, row_n;
  logic [PIN_W-1:0]     pin_idx, pin_idx_n;
  logic [DWELL_W-1:0]   dwell_cnt, dwell_n;
  logic [GAP_W-1:0]     gap_cnt, gap_n;
  logic [NUM_PINS-1:0]  pin_drive, pin_drive_n;
  logic                 last_pin, dwell_end, gap_end;

  assign last_pin  = (col == 7'(NUM_COLS - 1)) && (row == 7'(NUM_ROWS - 1));
  assign dwell_end = (dwell_cnt == DWELL_W'(DWELL_CYC - 1));
  assign gap_end   = (gap_cnt == GAP_W'(GAP_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      pin_idx   <= '0;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      pin_drive <= '0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      pin_idx   <= pin_idx_n;
      dwell_cnt <= dwell_n;
      gap_cnt   <= gap_n;
      pin_drive <= pin_drive_n;
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    pin_idx_n = pin_idx;
    dwell_n   = dwell_cnt;
    gap_n     = gap_cnt;
    if (!bus.run && state != IDLE) begin
      state_n   = IDLE;
      col_n     = '0;
      row_n     = '0;
      pin_idx_n = '0;
      dwell_n   = '0;
      gap_n     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.run) begin
            state_n   = ANNOUNCE;
            col_n     = '0;
            row_n     = '0;
            pin_idx_n = '0;
          end
        end
        ANNOUNCE: begin
          if (!bus.enc_busy) state_n = WAIT_ENC;
        end
        WAIT_ENC: begin
          if (!bus.enc_busy) begin
            state_n = DRIVE;
            dwell_n = '0;
          end
        end
        DRIVE: begin
          if (dwell_end) begin
            state_n = GAP;
            dwell_n = '0;
            gap_n   = '0;
          end else begin
            dwell_n = dwell_cnt + DWELL_W'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            gap_n = '0;
            if (last_pin) begin
              col_n     = '0;
              row_n     = '0;
              pin_idx_n = '0;
              state_n   = bus.loop ? ANNOUNCE : IDLE;
            end else begin
              // pin_idx tracks col*NUM_ROWS+row incrementally, avoiding a multiplier
              pin_idx_n = pin_idx + PIN_W'(1);
              state_n   = ANNOUNCE;
              if (row == 7'(NUM_ROWS - 1)) begin
                row_n = '0;
                col_n = col + 7'd1;
              end else begin
                row_n = row + 7'd1;
              end
            end
          end else begin
            gap_n = gap_cnt + GAP_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Computed from next-state values so the registered output lines up with DRIVE.
  always_comb begin
    pin_drive_n = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      pin_drive_n[i] = (state_n == DRIVE) && (pin_idx_n == PIN_W'(i)) && dwell_n[TOGGLE_DIV];
    end
  end

  assign bus.enc_start = !reset && bus.run && (state == ANNOUNCE) && !bus.enc_busy;
  assign bus.scan_done = !reset && bus.run && (state == GAP) && gap_end && last_pin;
  assign bus.busy      = (state != IDLE);
  assign bus.col       = col;
  assign bus.row       = row;
  assign bus.pin_drive = pin_drive;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_pin_scan_ctrl.sv
// Directed bench for pin_scan_ctrl on a 2x3 grid with a 4-cycle encoder model.
module tb_pin_scan_ctrl;
  localparam int NC = 2;
  localparam int NR = 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_ANN = 3'd1, S_WAIT = 3'd2, S_DRIVE = 3'd3, S_GAP = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pin_scan_ctrl_if #(.NUM_COLS(NC), .NUM_ROWS(NR)) bus ();

  pin_scan_ctrl #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .DWELL_CYC(8), .GAP_CYC(2), .TOGGLE_DIV(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  int start_cnt = 0;
  int done_cnt  = 0;
  int viol_cnt  = 0;

  // Encoder model: busy for 4 cycles starting the cycle after enc_start.
  int   enc_cnt = 0;
  logic enc_force = 1'b0;
  always @(posedge clk) begin
    if (bus.enc_start) enc_cnt <= 4;
    else if (enc_cnt != 0) enc_cnt <= enc_cnt - 1;
  end
  assign bus.enc_busy = (enc_cnt != 0) || enc_force;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Monitor: settled values just after inputs change at the falling edge.
  always @(negedge clk) begin
    #1;
    if ($countones(bus.pin_drive) > 1) viol_cnt++;
    if (bus.enc_start && bus.state_dbg != S_ANN) viol_cnt++;
    if (bus.scan_done) done_cnt++;
    if (bus.enc_start) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("enc_start_unexpected", 32'(1), 32'(0));
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        check_eq("enc_start_colrow", 32'({bus.col, bus.row}), 32'(e));
      end
    end
  end

  task automatic push_pin(input int c, input int r);
    exp_q.push_back({7'(c), 7'(r)});
  endtask

  task automatic push_scan();
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) push_pin(c, r);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int c, input int r, input int budget);
    int n = 0;
    while (!(bus.state_dbg == st && bus.col == 7'(c) && bus.row == 7'(r)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n < budget), 32'(1));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n < budget), 32'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_state"},     32'(bus.state_dbg), 32'(S_IDLE));
    check_eq({tag, "_busy"},      32'(bus.busy),      32'(0));
    check_eq({tag, "_enc_start"}, 32'(bus.enc_start), 32'(0));
    check_eq({tag, "_scan_done"}, 32'(bus.scan_done), 32'(0));
    check_eq({tag, "_pin_drive"}, 32'(bus.pin_drive), 32'(0));
    check_eq({tag, "_col"},       32'(bus.col),       32'(0));
    check_eq({tag, "_row"},       32'(bus.row),       32'(0));
  endtask

  initial begin
    logic [7:0] pat;
    logic [5:0] exp_pd;
    int s0;
    bus.run  = 1'b0;
    bus.loop = 1'b0;
    pat = 8'b1100_1100;

    // Reset state, held with run high to show reset priority.
    repeat (2) @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    bus.run = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Single scan, loop=0, with dwell pattern on pin (1,1).
    push_scan();
    bus.run = 1'b1;
    wait_state("reach_drive_1_1", S_DRIVE, 1, 1, 200);
    for (int i = 0; i < 8; i++) begin
      exp_pd = 6'(pat[i]) << 4;
      check_eq("drive_1_1_pattern", 32'(bus.pin_drive), 32'(exp_pd));
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      check_eq("gap_state", 32'(bus.state_dbg), 32'(S_GAP));
      check_eq("gap_pin_drive", 32'(bus.pin_drive), 32'(0));
      @(negedge clk);
    end
    wait_done("scan1_done", 200);
    check_eq("scan1_idle_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check_eq("scan1_idle_busy", 32'(bus.busy), 32'(0));
    bus.run = 1'b0;
    check_eq("scan1_done_cnt", 32'(done_cnt), 32'(1));
    check_eq("scan1_starts", 32'(start_cnt), 32'(6));
    check_eq("scan1_q_empty", 32'(exp_q.size()), 32'(0));

    // Encoder busy before ANNOUNCE holds off enc_start.
    @(negedge clk);
    enc_force = 1'b1;
    bus.run   = 1'b1;
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    check_eq("hold_state_announce", 32'(bus.state_dbg), 32'(S_ANN));
    check_eq("hold_no_start", 32'(start_cnt), 32'(s0));
    push_pin(0, 0);
    enc_force = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("hold_one_start", 32'(start_cnt), 32'(s0 + 1));
    check_eq("hold_wait_enc", 32'(bus.state_dbg), 32'(S_WAIT));
    bus.run = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort_wait");

    // Run dropped during DRIVE of (0,2), then restart from (0,0).
    push_pin(0, 0); push_pin(0, 1); push_pin(0, 2);
    bus.run = 1'b1;
    wait_state("reach_drive_0_2", S_DRIVE, 0, 2, 200);
    repeat (2) @(negedge clk);
    check_eq("drive_0_2_bit", 32'(bus.pin_drive), 32'(6'b000100));
    s0 = done_cnt;
    bus.run = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort_drive");
    check_eq("abort_no_done", 32'(done_cnt), 32'(s0));
    push_pin(0, 0);
    bus.run = 1'b1;
    wait_state("restart_wait_0_0", S_WAIT, 0, 0, 20);
    check_eq("restart_q_empty", 32'(exp_q.size()), 32'(0));
    bus.run = 1'b0;
    @(negedge clk);
    check_eq("restart_abort_state", 32'(bus.state_dbg), 32'(S_IDLE));

    // Looping scan, then reset mid-WAIT_ENC.
    push_scan();
    push_pin(0, 0); push_pin(0, 1);
    bus.loop = 1'b1;
    bus.run  = 1'b1;
    wait_done("loop_done", 300);
    check_eq("loop_no_idle_state", 32'(bus.state_dbg), 32'(S_ANN));
    check_eq("loop_no_idle_busy", 32'(bus.busy), 32'(1));
    wait_state("loop_wait_0_1", S_WAIT, 0, 1, 100);
    s0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_wait");
    check_eq("reset_no_done", 32'(done_cnt), 32'(s0));
    reset    = 1'b0;
    bus.run  = 1'b0;
    bus.loop = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("final_idle", 32'(bus.state_dbg), 32'(S_IDLE));

    check_eq("total_done", 32'(done_cnt), 32'(2));
    check_eq("final_q_empty", 32'(exp_q.size()), 32'(0));
    check_eq("invariants", 32'(viol_cnt), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "timeout");
  end
endmodule
